// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - default geometry and clear-FSM encoding for the multi-port register file
package regfile_pkg;

  localparam int RF_DW    = 32;
  localparam int RF_DEPTH = 32;
  localparam int RF_NR    = 2;
  localparam int RF_NW    = 1;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_rdmux.sv
// rtl/regfile_rdmux.sv - one asynchronous read port (array select, zero mask, REGFILE_BYPASS_EN forwarding)
module regfile_rdmux import regfile_pkg::*; #(
  parameter int DW      = RF_DW,
  parameter int DEPTH   = RF_DEPTH,
  parameter int AW      = $clog2(DEPTH),
  parameter int NW      = RF_NW,
  parameter int ZERO_R0 = 1
) (
  input  logic [DEPTH*DW-1:0] mem_flat,
  input  logic [AW-1:0]       raddr,
  input  logic [NW-1:0]       wen,
  input  logic [NW*AW-1:0]    waddr,
  input  logic [NW*DW-1:0]    wdata,
  input  logic                wr_idle,
  output logic [DW-1:0]       rdata
);

  logic is_zero_entry;

  assign is_zero_entry = (ZERO_R0 != 0) && (raddr == '0);

`ifndef REGFILE_BYPASS_EN
  // Write-side inputs only matter for forwarding; fold them away in the read-old build.
  logic unused_bypass;
  assign unused_bypass = ^{wen, waddr, wdata, wr_idle};
`endif

  // Select the addressed entry, optionally forward same-cycle write data, then mask entry 0.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == AW'(i)) rdata = mem_flat[i*DW +: DW];
    end
`ifdef REGFILE_BYPASS_EN
    // Ascending loop so the highest matching write port wins, mirroring write arbitration.
    for (int k = 0; k < NW; k++) begin
      if (wen[k] && wr_idle && (waddr[k*AW +: AW] == raddr) && !is_zero_entry)
        rdata = wdata[k*DW +: DW];
    end
`endif
    if (is_zero_entry) rdata = '0;
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - NW-write/NR-read register file with debug port and clear sequencer; option REGFILE_BYPASS_EN
module regfile_mp import regfile_pkg::*; #(
  parameter int DW      = RF_DW,
  parameter int DEPTH   = RF_DEPTH,
  parameter int AW      = $clog2(DEPTH),
  parameter int NR      = RF_NR,
  parameter int NW      = RF_NW,
  parameter int ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NW-1:0]     wen,
  input  logic [NW*AW-1:0]  waddr,
  input  logic [NW*DW-1:0]  wdata,
  input  logic [NR*AW-1:0]  raddr,
  output logic [NR*DW-1:0]  rdata,
  input  logic [AW-1:0]     test_addr,
  output logic [DW-1:0]     test_data,
  input  logic              clr_req,
  output logic              clr_busy
);

  logic [DW-1:0]       mem [DEPTH];
  logic [DEPTH*DW-1:0] mem_flat;

  rf_state_e           state_q, state_d;
  logic [AW-1:0]       clr_cnt_q, clr_cnt_d;
  logic                clr_busy_q, clr_busy_d;
  logic                wr_idle;

  assign wr_idle  = (state_q == RF_IDLE);
  assign clr_busy = clr_busy_q;

  // Clear-sequencer state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= RF_IDLE;
      clr_cnt_q  <= '0;
      clr_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      clr_busy_q <= clr_busy_d;
    end
  end

  // Clear-sequencer next state: one entry per cycle, exit after the last entry as the counter wraps.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    clr_busy_d = clr_busy_q;
    case (state_q)
      RF_IDLE: begin
        if (clr_req) begin
          state_d    = RF_CLEAR;
          clr_cnt_d  = '0;
          clr_busy_d = 1'b1;
        end
      end
      RF_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == AW'(DEPTH - 1)) begin
          state_d    = RF_IDLE;
          clr_busy_d = 1'b0;
        end
      end
      default: begin
        state_d    = RF_IDLE;
        clr_cnt_d  = '0;
        clr_busy_d = 1'b0;
      end
    endcase
  end

  // Array update: clearing owns the array; otherwise later write ports override earlier ones.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state_q == RF_CLEAR) begin
      mem[clr_cnt_q] <= '0;
    end else begin
      for (int k = 0; k < NW; k++) begin
        if (wen[k] && !((ZERO_R0 != 0) && (waddr[k*AW +: AW] == '0)))
          mem[waddr[k*AW +: AW]] <= wdata[k*DW +: DW];
      end
    end
  end

  // Flatten the array so each read port can be a self-contained mux.
  always_comb begin
    mem_flat = '0;
    for (int i = 0; i < DEPTH; i++) mem_flat[i*DW +: DW] = mem[i];
  end

  // Debug read: plain array view, never forwarded, entry 0 masked.
  always_comb begin
    test_data = mem[test_addr];
    if ((ZERO_R0 != 0) && (test_addr == '0)) test_data = '0;
  end

  for (genvar j = 0; j < NR; j++) begin : g_rd
    regfile_rdmux #(
      .DW      (DW),
      .DEPTH   (DEPTH),
      .AW      (AW),
      .NW      (NW),
      .ZERO_R0 (ZERO_R0)
    ) u_rdmux (
      .mem_flat (mem_flat),
      .raddr    (raddr[j*AW +: AW]),
      .wen      (wen),
      .waddr    (waddr),
      .wdata    (wdata),
      .wr_idle  (wr_idle),
      .rdata    (rdata[j*DW +: DW])
    );
  end

endmodule
